pipe_ctrl_n: RTL

Parametrised pipeline hazard controller: generalises the fixed five-stage stall/flush controller to `STAGES` stages with prefix stall masks, per-stage flush masks, a registered redirect with valid/ready handshake to the fetch unit, a debug halt/drain/resume state machine, and a stall watchdog. It sits beside the pipeline, takes stall requests and flush events from each stage, and drives every stage's stall and flush controls.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_n_stall_wdog.sv | 46 ++++
 rtl/pipe_ctrl_n.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Halt FSM states, flush source encoding and default stage indices.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    typedef enum logic [1:0] {
        FL_NONE = 2'd0,
        FL_BR   = 2'd1,
        FL_EXC  = 2'd2,
        FL_INT  = 2'd3
    } flush_src_e;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    localparam int WDOG_CNT_W = 16;

endpackage

// File: rtl/pipe_ctrl_n_stall_wdog.sv
// Saturating stall watchdog: counts stalled cycles, fires once the count
// reaches LIMIT and stays fired until the count is cleared.
module stall_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic timeout
);

    localparam logic [WDOG_CNT_W-1:0] LIMIT_V = WDOG_CNT_W'(LIMIT);

    logic [WDOG_CNT_W-1:0] count_q, count_d;
    logic                  timeout_q, timeout_d;

    // Hold wins over clear so a halted pipeline keeps its stall history.
    always_comb begin
        count_d = count_q;
        if (hold) begin
            count_d = count_q;
        end else if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT_V)) begin
            count_d = count_q + 1'b1;
        end
        timeout_d = (count_d == LIMIT_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl_n.sv
// Parametrised pipeline hazard controller: prefix stalls, prioritised
// flushes, registered fetch redirect, debug halt FSM and stall watchdog.
module pipe_ctrl_n
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES     = 5,
    parameter int EX_STAGE   = STAGE_EX,
    parameter int ADDR_W     = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic [STAGES-1:0] stage_valid_i,
    input  logic              br_flush_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    input  logic              exc_flush_i,
    input  logic [ADDR_W-1:0] exc_addr_i,
    input  logic              int_assert_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    output logic              int_ack_o,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    input  logic              redirect_ready_i,
    input  logic              haltreq_i,
    input  logic              resumereq_i,
    output logic              halted_o,
    output logic              wdog_timeout_o
);

    halt_state_e       state_q, state_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;

    logic [STAGES-1:0] stall_base;
    logic [STAGES-1:0] br_mask;
    logic [STAGES-1:0] stall_int;
    logic [STAGES-1:0] flush_int;
    logic [ADDR_W-1:0] flush_addr;
    flush_src_e        flush_sel;

    // A stalling stage freezes itself and everything upstream of it.
    for (genvar k = 0; k < STAGES; k++) begin : g_mask
        assign stall_base[k] = |stall_req_i[STAGES-1:k];
        assign br_mask[k]    = (k < EX_STAGE);
    end

    always_comb begin
        stall_int = stall_base;
        if (redirect_valid_q || (state_q == ST_DRAIN)) begin
            stall_int[0] = 1'b1;
        end
        if (state_q == ST_HALTED) begin
            stall_int = '1;
        end
    end

    always_comb begin
        flush_sel = FL_NONE;
        if (!rst && (state_q != ST_HALTED)) begin
            if (int_assert_i && !stall_int[STAGES-1]) begin
                flush_sel = FL_INT;
            end else if (exc_flush_i && !stall_int[STAGES-1]) begin
                flush_sel = FL_EXC;
            end else if (br_flush_i && !stall_int[EX_STAGE]) begin
                flush_sel = FL_BR;
            end
        end
    end

    always_comb begin
        flush_int  = '0;
        flush_addr = '0;
        case (flush_sel)
            FL_INT: begin
                flush_int  = '1;
                flush_addr = int_addr_i;
            end
            FL_EXC: begin
                flush_int  = '1;
                flush_addr = exc_addr_i;
            end
            FL_BR: begin
                flush_int  = br_mask;
                flush_addr = br_addr_i;
            end
            default: begin
                flush_int  = '0;
                flush_addr = '0;
            end
        endcase
    end

    assign stall_o   = rst ? '0 : stall_int;
    assign flush_o   = flush_int;
    assign int_ack_o = (flush_sel == FL_INT);

    // A fresh flush always takes the redirect slot, even over a handshake.
    always_comb begin
        redirect_valid_d = redirect_valid_q;
        redirect_addr_d  = redirect_addr_q;
        if (flush_sel != FL_NONE) begin
            redirect_valid_d = 1'b1;
            redirect_addr_d  = flush_addr;
        end else if (redirect_ready_i) begin
            redirect_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (haltreq_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!haltreq_i) begin
                    state_d = ST_RUN;
                end else if ((stage_valid_i == '0) && !redirect_valid_q) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (resumereq_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            redirect_valid_q <= 1'b0;
            redirect_addr_q  <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_addr_q  <= redirect_addr_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_addr_o  = redirect_addr_q;
    assign halted_o         = (state_q == ST_HALTED);

    stall_wdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_stall_wdog (
        .clk     (clk),
        .rst     (rst),
        .inc     (stall_int != '0),
        .clr     (stall_int == '0),
        .hold    (state_q == ST_HALTED),
        .timeout (wdog_timeout_o)
    );

endmodule
